// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants: opcode values, reset values and the
// fetch FSM state encoding.
package riscv_pkg;

  localparam logic [6:0] INST_R    = 7'b0110011;
  localparam logic [6:0] INST_I    = 7'b0010011;
  localparam logic [6:0] INST_L    = 7'b0000011;
  localparam logic [6:0] INST_S    = 7'b0100011;
  localparam logic [6:0] INST_B    = 7'b1100011;
  localparam logic [6:0] INST_LUI  = 7'b0110111;
  localparam logic [6:0] INST_JAL  = 7'b1101111;
  localparam logic [6:0] INST_JALR = 7'b1100111;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } if_state_e;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC select: jump (relative or absolute) beats
// sequential increment; with neither request the PC holds.
module pc_next (
  input  logic [31:0] pc,
  input  logic [31:0] pc_cur,
  input  logic [31:0] imm,
  input  logic [31:0] jump_addr,
  input  logic        pc_jump,
  input  logic        pc_jump_sel,
  input  logic        pc_go_next,
  output logic [31:0] pc_nxt
);

  always_comb begin
    pc_nxt = pc;
    if (pc_jump) begin
      // absolute targets come from the ALU and follow JALR: bit 0 cleared
      pc_nxt = pc_jump_sel ? {jump_addr[31:1], 1'b0} : pc_cur + imm;
    end else if (pc_go_next) begin
      pc_nxt = pc + 32'd4;
    end
  end

endmodule

// File: rtl/if_unit.sv
// Instruction fetch unit: PC register, one-outstanding-request fetch FSM
// and instruction register with decoded field taps.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no fetch outstanding; PC may be updated, ir_write starts fetch
// ST_WAIT | imem_req high at imem_addr = pc, waiting for imem_ack
module if_unit #(
  parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = riscv_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_write,
  input  logic        pc_go_next,
  input  logic        pc_jump,
  input  logic        pc_jump_sel,
  input  logic [31:0] imm,
  input  logic [31:0] jump_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_cur,
  output logic [31:0] ir,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic        fetch_done,
  output logic        busy,
  output logic        misalign
);
  import riscv_pkg::*;

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_cur_q, ir_q, pc_nxt;
  logic        fetch_done_q, misalign_q;
  logic        fetch_start, fetch_end;

  pc_next u_pc_next (
    .pc          (pc_q),
    .pc_cur      (pc_cur_q),
    .imm         (imm),
    .jump_addr   (jump_addr),
    .pc_jump     (pc_jump),
    .pc_jump_sel (pc_jump_sel),
    .pc_go_next  (pc_go_next),
    .pc_nxt      (pc_nxt)
  );

  always_comb begin
    state_d     = state_q;
    fetch_start = 1'b0;
    fetch_end   = 1'b0;
    busy        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        fetch_start = ir_write;
        if (ir_write) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        busy      = 1'b1;
        fetch_end = imem_ack;
        if (imem_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      pc_cur_q     <= RESET_PC;
      ir_q         <= NOP_INST;
      fetch_done_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_done_q <= fetch_end;
      if (fetch_end) begin
        ir_q     <= imem_rdata;
        pc_cur_q <= pc_q;
      end
      // PC is frozen while a fetch is outstanding
      if (state_q == ST_IDLE) pc_q <= pc_nxt;
      if (fetch_start && (pc_q[1:0] != 2'b00)) misalign_q <= 1'b1;
    end
  end

  assign imem_req   = busy;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign pc_cur     = pc_cur_q;
  assign ir         = ir_q;
  assign opcode     = ir_q[6:0];
  assign funct3     = ir_q[14:12];
  assign funct7     = ir_q[31:25];
  assign fetch_done = fetch_done_q;
  assign misalign   = misalign_q;

endmodule

// File: doc/if_unit.md
IF_UNIT -- requirements
Module: if_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013, IR value loaded on reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ir_write  input  1  fetch request from control unit, one-cycle pulse.
REQ-006 SHALL have port pc_go_next  input  1  PC <= PC + 4.
REQ-007 SHALL have port pc_jump  input  1  load a jump target into PC.
REQ-008 SHALL have port pc_jump_sel  input  1  jump target select: 0 = pc_cur + imm (relative), 1 = jump_addr (absolute).
REQ-009 SHALL have port imm  input  32  sign-extended relative offset.
REQ-010 SHALL have port jump_addr  input  32  absolute target from ALU result.
REQ-011 SHALL have port imem_req  output  1  instruction memory request.
REQ-012 SHALL have port imem_addr  output  32  fetch address.
REQ-013 SHALL have port imem_ack  input  1  memory returns data this cycle.
REQ-014 SHALL have port imem_rdata  input  32  instruction word, valid when imem_ack = 1.
REQ-015 SHALL have port pc  output  32  next fetch address.
REQ-016 SHALL have port pc_cur  output  32  address of the instruction currently held in IR.
REQ-017 SHALL have port ir  output  32  instruction register.
REQ-018 SHALL have port opcode/funct3/funct7  output  7/3/7  ir[6:0], ir[14:12], ir[31:25] (combinational from IR).
REQ-019 SHALL have port fetch_done  output  1  one-cycle pulse after IR is loaded.
REQ-020 SHALL have port busy  output  1  fetch in progress.
REQ-021 SHALL have port misalign  output  1  sticky: a fetch was issued with pc[1:0] != 0.

Function
REQ-022 SHALL implement FSM states IDLE and WAIT; busy = (state == WAIT).
REQ-023 In IDLE, ir_write = 1 SHALL move the FSM to WAIT on the next edge; in WAIT, imem_req = 1 and imem_addr = pc.
REQ-024 In WAIT, while imem_ack = 1 at an edge, the block SHALL load ir <= imem_rdata and pc_cur <= pc, move to IDLE, and set fetch_done = 1 for exactly the following cycle.
REQ-025 Minimum latency SHALL be: ir_write sampled at edge N, ack sampled at edge N+1, IR valid after N+1. Ack may arrive any number of cycles later; imem_req stays high until ack.
REQ-026 imem_req SHALL be 0 in IDLE; imem_ack received in IDLE SHALL be ignored.
REQ-027 ir_write received in WAIT SHALL be ignored (no queuing).
REQ-028 In IDLE, pc_jump = 1 SHALL load pc <= (pc_jump_sel ? {jump_addr[31:1],1'b0} : pc_cur + imm); otherwise pc_go_next = 1 SHALL load pc <= pc + 4.
REQ-029 When pc_jump and pc_go_next are both asserted, the jump SHALL win.
REQ-030 pc_go_next and pc_jump asserted in WAIT SHALL be ignored; pc SHALL be stable during a fetch.
REQ-031 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 = 0, with no flag.
REQ-032 Entering WAIT with pc[1:0] != 0 SHALL set misalign; the fetch still proceeds with imem_addr = pc unmodified.

Reset
REQ-033 When rst = 1 at an edge, the block SHALL set pc <= RESET_PC, pc_cur <= RESET_PC, ir <= NOP_INST, state <= IDLE, fetch_done <= 0, and misalign <= 0.
REQ-034 Reset in WAIT SHALL abort the fetch: imem_req = 0 from the next cycle, and a late ack SHALL be ignored.
REQ-035 rst SHALL take priority over every other input in the same cycle.

Structure
REQ-036 The shared package riscv_pkg SHALL hold the opcode constants (INST_R, INST_I, INST_L, INST_S, INST_B, INST_LUI, INST_JAL, INST_JALR), RESET_PC, NOP_INST and the FSM state encoding.
REQ-037 The next-PC selection SHALL be a single combinational sub-module, pc_next; the FSM and registers stay in if_unit.

Verification
REQ-038 Scenario: reset, then ir_write pulse, ack one cycle later with rdata=32'h0050_0093 -> imem_addr=0; ir=32'h0050_0093, opcode=7'h13, pc_cur=0; fetch_done high exactly one cycle.
REQ-039 Scenario: ack delayed 5 cycles, with pc_go_next pulsed during WAIT -> imem_req held 5 cycles; pc unchanged at 0; later pc_go_next in IDLE gives pc=4.
REQ-040 Scenario: pc_cur=32'h0000_0010, imm=32'hFFFF_FFF8, pc_jump=1, pc_jump_sel=0, pc_go_next=1 -> pc=32'h0000_0008.
REQ-041 Scenario: pc_jump=1, pc_jump_sel=1, jump_addr=32'h0000_0101 -> pc=32'h0000_0100; misalign stays 0 on the next fetch.
REQ-042 Scenario: pc=32'hFFFF_FFFC, pc_go_next -> pc=0; jump to 32'h0000_0002 (relative) then ir_write -> misalign=1 and stays 1 until reset.
REQ-043 Scenario: rst asserted in WAIT, ack the cycle after -> ir=32'h0000_0013, pc=0, imem_req=0, no fetch_done.
